// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory arbiter: widths, port ids and
// memory write-enable polarity.
package dmem_pkg;
    localparam int DMEM_DATA_WIDTH = 32;
    localparam int DMEM_ADDR_WIDTH = 10;
    localparam int BURST_W         = 4;

    localparam logic PORT_CPU      = 1'b0;
    localparam logic PORT_DMA      = 1'b1;
    localparam logic MEM_WE_ACTIVE = 1'b0;
endpackage

// File: rtl/dmem_prio_grant.sv
// Fixed-priority grant for two requesters; starve flips priority to port 1
// when both are requesting.
module dmem_prio_grant
    import dmem_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic starve,
    output logic gnt0,
    output logic gnt1,
    output logic sel
);
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        sel  = PORT_CPU;
        if (req1 && (!req0 || starve)) begin
            gnt1 = 1'b1;
            sel  = PORT_DMA;
        end else if (req0) begin
            gnt0 = 1'b1;
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data memory with
// anti-starvation for port 1 and one-cycle read-response routing.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_we_n,
    input  logic [DATA_WIDTH-1:0] mem_dout
);
    // Handshake: a request is accepted in any cycle where reqX and gntX are
    // both high; the requester keeps weX/addrX/wdataX stable until then.
    logic [BURST_W-1:0]    burst_cnt_q, burst_cnt_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  rd_owner_q, rd_owner_d;
    logic [ADDR_WIDTH-1:0] addr_hold_q, addr_hold_d;
    logic [DATA_WIDTH-1:0] din_hold_q, din_hold_d;
    logic                  starve, sel, any_gnt, win_we;

    assign starve = (burst_cnt_q == BURST_W'(MAX_BURST));

    dmem_prio_grant u_grant (
        .req0   (req0 & ~rst),
        .req1   (req1 & ~rst),
        .starve (starve),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .sel    (sel)
    );

    always_comb begin
        any_gnt  = gnt0 | gnt1;
        win_we   = (sel == PORT_DMA) ? we1 : we0;
        mem_addr = addr_hold_q;
        mem_din  = din_hold_q;
        mem_we_n = ~MEM_WE_ACTIVE;
        if (any_gnt) begin
            mem_addr = (sel == PORT_DMA) ? addr1 : addr0;
            mem_din  = (sel == PORT_DMA) ? wdata1 : wdata0;
            mem_we_n = win_we ? MEM_WE_ACTIVE : ~MEM_WE_ACTIVE;
        end
        addr_hold_d = mem_addr;
        din_hold_d  = mem_din;
        rd_pend_d   = any_gnt & ~win_we;
        rd_owner_d  = any_gnt ? sel : rd_owner_q;

        burst_cnt_d = burst_cnt_q;
        if (gnt1 || !req1) begin
            burst_cnt_d = '0;
        end else if (gnt0 && !starve) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt_q <= '0;
            rd_pend_q   <= 1'b0;
            rd_owner_q  <= PORT_CPU;
            addr_hold_q <= '0;
            din_hold_q  <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
            rd_pend_q   <= rd_pend_d;
            rd_owner_q  <= rd_owner_d;
            addr_hold_q <= addr_hold_d;
            din_hold_q  <= din_hold_d;
        end
    end

    // Gating with rst drops a response that is due in the same cycle reset rises.
    assign rvalid0 = rd_pend_q & (rd_owner_q == PORT_CPU) & ~rst;
    assign rvalid1 = rd_pend_q & (rd_owner_q == PORT_DMA) & ~rst;
    assign rdata0  = mem_dout;
    assign rdata1  = mem_dout;
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory between two requesters:
  - port 0: CPU load/store stage
  - port 1: DMA/loader
- Memory side is one-cycle read latency, registered address, active-low write enable.
- Fixed priority to port 0, with an anti-starvation counter that forces a port 1 grant after MAX_BURST consecutive port 0 grants while port 1 waits.
- Tracks the in-flight read and routes returned data to its owner.

Parameters:
- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 10, word address width
- MAX_BURST, 4, max consecutive port 0 grants while port 1 is pending (range 1..15)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req0  in  1  port 0 request valid
- we0  in  1  port 0 write (1) / read (0)
- addr0  in  ADDR_WIDTH  port 0 address
- wdata0  in  DATA_WIDTH  port 0 write data
- gnt0  out  1  port 0 request accepted this cycle
- rvalid0  out  1  port 0 read data valid
- rdata0  out  DATA_WIDTH  port 0 read data
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1
- mem_addr  out  ADDR_WIDTH  memory address
- mem_din  out  DATA_WIDTH  memory write data
- mem_we_n  out  1  memory write enable, active-low
- mem_dout  in  DATA_WIDTH  memory read data, valid the cycle after the address is presented

Behaviour:
- Reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - burst_cnt=0, rd_pend=0, rd_owner=0
  - rvalid0 = rvalid1 = 0
  - mem_we_n=1
  - gnt0 = gnt1 = 0 while rst is high
- Grant logic is combinational from req0, req1 and burst_cnt. At most one gnt per cycle.
  - Only req0: gnt0=1.
  - Only req1: gnt1=1.
  - Both: gnt1=1 if burst_cnt==MAX_BURST, else gnt0=1.
  - Neither: no grant. mem_we_n=1 and mem_addr holds its last value (no write occurs).
- Transfer: a request completes in the cycle where req and gnt are both high.
  - mem_addr, mem_din and mem_we_n = ~we are driven from the winning port in that same cycle.
  - The requester holds addr, wdata and we stable until granted.
- Write: committed at the rising edge ending the grant cycle. No response is returned.
- Read: rd_pend<=1 and rd_owner<=winner at the grant edge.
  - In the next cycle, rvalidX=1 for the owner and rdataX=mem_dout; the other port's rvalid stays 0.
  - Latency is exactly 1 cycle after the grant.
- Back-to-back grants are allowed every cycle. A read response and a new grant can overlap.
- rdata of the non-owner port is don't-care; the bench must compare only when rvalid=1.
- burst_cnt update, one rule per cycle:
  - gnt0 with req1=1: burst_cnt <= burst_cnt+1.
  - gnt1: burst_cnt <= 0.
  - req1=0: burst_cnt <= 0.
  - burst_cnt saturates at MAX_BURST and never wraps.
- Same-address write then read: the read granted the cycle after a write returns the new data (memory semantics; the arbiter adds no bypass).
- Reset mid-read: a pending rvalid is cancelled. rvalid0 = rvalid1 = 0 in the cycle following the reset edge, and in-flight data is dropped.
- No combinational path from mem_dout to any gnt output.

Decomposition:
- Shared package dmem_pkg:
  - DMEM_DATA_WIDTH and DMEM_ADDR_WIDTH constants
  - port-id constants PORT_CPU=0 and PORT_DMA=1
  - MEM_WE_ACTIVE=1'b0, the write-enable polarity constant
- One sub-module: dmem_prio_grant, purely combinational. Inputs req0, req1, starve; outputs gnt0, gnt1, sel.
- Counter, read tracker and muxes stay in dmem_arbiter.

Test Plan:
- Reset then idle: rst high 3 cycles, no requests -> mem_we_n=1, gnt0 = gnt1 = rvalid0 = rvalid1 = 0 throughout.
- Single port 0 write then read: write addr 5, data 0xDEADBEEF; next cycle read addr 5 -> gnt0 each cycle, mem_we_n=0 only in the write cycle, rvalid0=1 with rdata0=0xDEADBEEF one cycle after the read grant.
- Starvation guard, MAX_BURST=4: req0 and req1 held continuously, all reads -> grant sequence 0,0,0,0,1,0,0,0,0,1, and burst_cnt returns to 0 after each gnt1.
- Interleaved reads: port 0 reads addr 1, port 1 reads addr 2 in consecutive cycles, memory preloaded with 4001 and 5001 -> rvalid0 with 4001 in cycle n+1, rvalid1 with 5001 in cycle n+2, never both high.
- Port 1 alone, 10 back-to-back writes to addrs 0..9 -> gnt1 every cycle, burst_cnt stays 0, readback via port 0 matches.
- Reset during pending read: read granted in cycle n, rst high in cycle n+1 -> rvalid0=0 from cycle n+1 onward, burst_cnt=0.
